bsg_cache_nb_txn_monitor: RTL and testbench
===========================================

Name: bsg_cache_nb_txn_monitor

Overview:
- Multi-port transaction monitor for non-blocking cache benches and SoC-level sanity checking.
- Tracks outstanding requests per port, weighting block loads by block size, and flags overflow, underflow and response-timeout errors.
- Runs a drain/done state machine once the stimulus source reports completion.
- Generalises the single-port sent/received counting in the cache regression bench to N ports, with error detection and a watchdog.

Parameters:
- num_ports_p, 2: number of independent request/response channels.
- block_size_in_words_p, 8: weight added for a block-load request.
- max_outstanding_p, 64: per-port outstanding limit. Counter width is `BSG_SAFE_CLOG2(max_outstanding_p+1).
- timeout_p, 1024: cycles with outstanding>0 and no response before a timeout error. 0 disables the watchdog.
- lg_ports_lp, derived: `BSG_SAFE_CLOG2(num_ports_p).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_v_i  in  num_ports_p  request valid per port
- req_ready_i  in  num_ports_p  request ready per port; fire = req_v_i & req_ready_i
- req_block_i  in  num_ports_p  request is a block load (weight block_size_in_words_p, else 1)
- resp_v_i  in  num_ports_p  response valid per port
- resp_yumi_i  in  num_ports_p  response consumed; fire = resp_v_i & resp_yumi_i
- src_done_i  in  1  stimulus source finished (level)
- outstanding_o  out  num_ports_p*cnt_width  per-port outstanding count, port 0 in LSBs
- done_o  out  1  all ports drained after src_done_i
- error_o  out  1  sticky error
- error_code_o  out  2  0 none, 1 overflow, 2 underflow, 3 timeout
- error_port_o  out  lg_ports_lp  port of first error

Behaviour:
- Reset (async, reset_n_i=0): all counters and watchdogs cleared; state IDLE; done_o=0, error_o=0, error_code_o=0, error_port_o=0. Reset mid-operation discards all state immediately.
- Per-port update each cycle: next = cnt + (req fire ? weight : 0) - (resp fire ? 1 : 0).
  - Simultaneous req and resp are netted in one update.
  - Arithmetic is one bit wider than cnt_width.
- Overflow: next > max_outstanding_p → counter saturates at max_outstanding_p; raise overflow.
- Underflow: resp fire while cnt==0 and no same-cycle req fire → counter holds 0; raise underflow.
- Watchdog per port:
  - Cleared on resp fire or when cnt==0.
  - Increments while cnt>0; reaching timeout_p raises timeout.
  - Saturates at timeout_p.
- Error capture: only the first error is latched into code/port.
  - If several occur in the same cycle, the lowest port index wins; within a port, priority is overflow > underflow > timeout.
  - error_o is asserted the cycle after the event and stays set until reset.
- FSM:
  - IDLE → RUN on any req fire.
  - RUN → DRAIN when src_done_i=1.
  - DRAIN → DONE when all counters are 0, evaluated on registered counts with no fire that cycle.
  - Any state → ERROR when an error is latched. ERROR is terminal.
  - IDLE with src_done_i=1 and no traffic → DONE directly.
  - DONE → RUN if a new req fire arrives (done_o deasserts).
  - src_done_i falling in DRAIN → back to RUN.
- done_o = (state==DONE), registered.

Optional Feature:
- Macro BSG_CACHE_NB_TXN_MONITOR_STATS_EN.
- When defined, add outputs:
  - total_req_o (num_ports_p*32): weighted request totals, wrapping.
  - total_resp_o (num_ports_p*32): response totals, wrapping.
  - hwm_o (num_ports_p*cnt_width): outstanding high-water mark.
  - All three reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package bsg_cache_nb_txn_monitor_pkg holds:
  - error code enum: e_err_none, e_err_overflow, e_err_underflow, e_err_timeout.
  - FSM state enum: e_idle, e_run, e_drain, e_done, e_error.
- Sub-module bsg_cache_nb_txn_port_counter holds one port's counter, watchdog, per-port error flags and optional stats. The top instantiates num_ports_p copies and owns the FSM and first-error arbitration.

Test Plan:
- Port0: 5 single reqs, 5 resps, then src_done_i → outstanding_o[0] peaks at 5; done_o=1 within 2 cycles of the last resp; error_o=0.
- Port1: 1 block req plus 1 single req in the same cycle on port0, then 9 resps total split 8/1 → counts 8 and 1 → 0, done_o=1.
- max_outstanding_p=4: 5 single reqs on port1 → count saturates at 4; error_o=1, error_code_o=1, error_port_o=1.
- Resp fire on port0 with cnt=0, simultaneously on port1 with cnt=0 → error_code_o=2, error_port_o=0; count stays 0.
- timeout_p=16: 1 req on port1, no resp → error_code_o=3 exactly 16 cycles after the req fire; state ERROR.
- Assert reset_n_i low mid-DRAIN with counts 3/2 → outputs 0 asynchronously; after release, src_done_i alone → done_o=1.

Source files
------------

// File: rtl/bsg_cache_nb_txn_monitor_pkg.sv
// ============================================================================
// Module  : bsg_cache_nb_txn_monitor_pkg
// Brief   : Shared enums and sizing helper for the non-blocking cache
//           transaction monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_cache_nb_txn_monitor_pkg;

    typedef enum logic [1:0] {
        e_err_none      = 2'd0,
        e_err_overflow  = 2'd1,
        e_err_underflow = 2'd2,
        e_err_timeout   = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        e_idle  = 3'd0,
        e_run   = 3'd1,
        e_drain = 3'd2,
        e_done  = 3'd3,
        e_error = 3'd4
    } state_e;

    // ceil(log2(x)), never less than 1 so degenerate sizes still yield a legal vector
    function automatic int safe_clog2(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < x) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_cache_nb_txn_port_counter.sv
// ============================================================================
// Module  : bsg_cache_nb_txn_port_counter
// Brief   : One port's outstanding counter, response watchdog and error flags.
//           Optional statistics under BSG_CACHE_NB_TXN_MONITOR_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_cache_nb_txn_port_counter
    import bsg_cache_nb_txn_monitor_pkg::*;
#(
    parameter int block_size_in_words_p = 8,
    parameter int max_outstanding_p     = 64,
    parameter int timeout_p             = 1024
)
(
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic                                         req_fire_i,
    input  logic                                         req_block_i,
    input  logic                                         resp_fire_i,
    output logic [safe_clog2(max_outstanding_p+1)-1:0]   cnt_o,
    output logic                                         overflow_o,
    output logic                                         underflow_o,
    output logic                                         timeout_o
`ifdef BSG_CACHE_NB_TXN_MONITOR_STATS_EN
    ,
    output logic [31:0]                                  total_req_o,
    output logic [31:0]                                  total_resp_o,
    output logic [safe_clog2(max_outstanding_p+1)-1:0]   hwm_o
`endif
);

    localparam int cnt_width_lp = safe_clog2(max_outstanding_p + 1);
    // wide enough that cnt + block weight never wraps before the saturation check
    localparam int sum_width_lp = safe_clog2(max_outstanding_p + block_size_in_words_p + 1) + 1;
    localparam int wd_width_lp  = safe_clog2(timeout_p + 1);

    localparam logic [sum_width_lp-1:0] c_max     = sum_width_lp'(max_outstanding_p);
    localparam logic [sum_width_lp-1:0] c_block   = sum_width_lp'(block_size_in_words_p);
    localparam logic [wd_width_lp-1:0]  c_timeout = wd_width_lp'(timeout_p);

    logic [cnt_width_lp-1:0] r_cnt;
    logic [cnt_width_lp-1:0] w_cnt_next;
    logic [sum_width_lp-1:0] w_weight;
    logic [sum_width_lp-1:0] w_sum;
    logic [wd_width_lp-1:0]  r_wd;
    logic [wd_width_lp-1:0]  w_wd_next;

    always_comb begin
        w_weight = '0;
        if (req_fire_i) begin
            w_weight = req_block_i ? c_block : sum_width_lp'(1);
        end
        w_sum = sum_width_lp'(r_cnt) + w_weight
              - (resp_fire_i ? sum_width_lp'(1) : sum_width_lp'(0));

        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        w_cnt_next  = w_sum[cnt_width_lp-1:0];
        if (resp_fire_i && !req_fire_i && (r_cnt == '0)) begin
            underflow_o = 1'b1;
            w_cnt_next  = '0;
        end else if (w_sum > c_max) begin
            overflow_o = 1'b1;
            w_cnt_next = cnt_width_lp'(max_outstanding_p);
        end
    end

    always_comb begin
        w_wd_next = r_wd;
        timeout_o = 1'b0;
        if ((timeout_p == 0) || resp_fire_i || (r_cnt == '0)) begin
            w_wd_next = '0;
        end else if (r_wd < c_timeout) begin
            w_wd_next = r_wd + wd_width_lp'(1);
            timeout_o = (r_wd == (c_timeout - wd_width_lp'(1)));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
            r_wd  <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_wd  <= w_wd_next;
        end
    end

    assign cnt_o = r_cnt;

`ifdef BSG_CACHE_NB_TXN_MONITOR_STATS_EN
    logic [31:0]             r_total_req;
    logic [31:0]             r_total_resp;
    logic [cnt_width_lp-1:0] r_hwm;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_total_req  <= '0;
            r_total_resp <= '0;
            r_hwm        <= '0;
        end else begin
            r_total_req  <= r_total_req + 32'(w_weight);
            r_total_resp <= r_total_resp + (resp_fire_i ? 32'd1 : 32'd0);
            if (w_cnt_next > r_hwm) r_hwm <= w_cnt_next;
        end
    end

    assign total_req_o  = r_total_req;
    assign total_resp_o = r_total_resp;
    assign hwm_o        = r_hwm;
`endif

endmodule

`default_nettype wire

// File: rtl/bsg_cache_nb_txn_monitor.sv
// ============================================================================
// Module  : bsg_cache_nb_txn_monitor
// Brief   : N-port outstanding-transaction monitor with first-error capture
//           and drain/done FSM. Stats via BSG_CACHE_NB_TXN_MONITOR_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_cache_nb_txn_monitor
    import bsg_cache_nb_txn_monitor_pkg::*;
#(
    parameter int num_ports_p           = 2,
    parameter int block_size_in_words_p = 8,
    parameter int max_outstanding_p     = 64,
    parameter int timeout_p             = 1024
)
(
    input  logic                                                   clk_i,
    input  logic                                                   reset_n_i,
    input  logic [num_ports_p-1:0]                                 req_v_i,
    input  logic [num_ports_p-1:0]                                 req_ready_i,
    input  logic [num_ports_p-1:0]                                 req_block_i,
    input  logic [num_ports_p-1:0]                                 resp_v_i,
    input  logic [num_ports_p-1:0]                                 resp_yumi_i,
    input  logic                                                   src_done_i,
    output logic [num_ports_p*safe_clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                                   done_o,
    output logic                                                   error_o,
    output logic [1:0]                                             error_code_o,
    output logic [safe_clog2(num_ports_p)-1:0]                     error_port_o
`ifdef BSG_CACHE_NB_TXN_MONITOR_STATS_EN
    ,
    output logic [num_ports_p*32-1:0]                              total_req_o,
    output logic [num_ports_p*32-1:0]                              total_resp_o,
    output logic [num_ports_p*safe_clog2(max_outstanding_p+1)-1:0] hwm_o
`endif
);

    localparam int cnt_width_lp = safe_clog2(max_outstanding_p + 1);
    localparam int lg_ports_lp  = safe_clog2(num_ports_p);

    logic [num_ports_p-1:0] w_req_fire;
    logic [num_ports_p-1:0] w_resp_fire;
    logic [num_ports_p-1:0] w_ovf;
    logic [num_ports_p-1:0] w_unf;
    logic [num_ports_p-1:0] w_tmo;

    assign w_req_fire  = req_v_i & req_ready_i;
    assign w_resp_fire = resp_v_i & resp_yumi_i;

    for (genvar p = 0; p < num_ports_p; p++) begin : g_port
        bsg_cache_nb_txn_port_counter #(
            .block_size_in_words_p (block_size_in_words_p),
            .max_outstanding_p     (max_outstanding_p),
            .timeout_p             (timeout_p)
        ) u_port (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .req_fire_i  (w_req_fire[p]),
            .req_block_i (req_block_i[p]),
            .resp_fire_i (w_resp_fire[p]),
            .cnt_o       (outstanding_o[p*cnt_width_lp +: cnt_width_lp]),
            .overflow_o  (w_ovf[p]),
            .underflow_o (w_unf[p]),
            .timeout_o   (w_tmo[p])
`ifdef BSG_CACHE_NB_TXN_MONITOR_STATS_EN
            ,
            .total_req_o  (total_req_o[p*32 +: 32]),
            .total_resp_o (total_resp_o[p*32 +: 32]),
            .hwm_o        (hwm_o[p*cnt_width_lp +: cnt_width_lp])
`endif
        );
    end

    logic                   w_evt;
    err_code_e              w_evt_code;
    logic [lg_ports_lp-1:0] w_evt_port;

    // descending scan so the lowest-numbered erroring port is the one left standing
    always_comb begin
        w_evt      = 1'b0;
        w_evt_code = e_err_none;
        w_evt_port = '0;
        for (int p = num_ports_p - 1; p >= 0; p--) begin
            if (w_ovf[p] || w_unf[p] || w_tmo[p]) begin
                w_evt      = 1'b1;
                w_evt_port = lg_ports_lp'(p);
                w_evt_code = w_ovf[p] ? e_err_overflow :
                             w_unf[p] ? e_err_underflow : e_err_timeout;
            end
        end
    end

    logic                   r_error;
    err_code_e              r_error_code;
    logic [lg_ports_lp-1:0] r_error_port;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_error      <= 1'b0;
            r_error_code <= e_err_none;
            r_error_port <= '0;
        end else if (w_evt && !r_error) begin
            r_error      <= 1'b1;
            r_error_code <= w_evt_code;
            r_error_port <= w_evt_port;
        end
    end

    state_e r_state;
    state_e w_state_next;
    logic   w_any_req;
    logic   w_any_fire;
    logic   w_all_zero;

    assign w_any_req  = |w_req_fire;
    assign w_any_fire = w_any_req | (|w_resp_fire);
    assign w_all_zero = (outstanding_o == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            e_idle: begin
                if (w_any_req)       w_state_next = e_run;
                else if (src_done_i) w_state_next = e_done;
            end
            e_run: begin
                if (src_done_i) w_state_next = e_drain;
            end
            e_drain: begin
                if (!src_done_i)                   w_state_next = e_run;
                else if (w_all_zero && !w_any_fire) w_state_next = e_done;
            end
            e_done: begin
                if (w_any_req) w_state_next = e_run;
            end
            e_error: w_state_next = e_error;
            default: w_state_next = e_idle;
        endcase
        if (w_evt) w_state_next = e_error;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= e_idle;
        else            r_state <= w_state_next;
    end

    assign done_o       = (r_state == e_done);
    assign error_o      = r_error;
    assign error_code_o = r_error_code;
    assign error_port_o = r_error_port;

endmodule

`default_nettype wire

// File: tb/tb_bsg_cache_nb_txn_monitor.sv
// ============================================================================
// Module  : tb_bsg_cache_nb_txn_monitor
// Brief   : Self-checking bench; two monitor instances (max 64/timeout 16 and
//           max 4/no watchdog) share stimulus, counts checked via a scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_cache_nb_txn_monitor;

    localparam int CW_M = 7;
    localparam int CW_S = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req_v = '0, req_ready = '0, req_block = '0, resp_v = '0, resp_yumi = '0;
    logic       src_done = 1'b0;

    logic [2*CW_M-1:0] out_m;
    logic [2*CW_S-1:0] out_s;
    logic              done_m, err_m, done_s, err_s;
    logic [1:0]        code_m, code_s;
    logic [0:0]        port_m, port_s;
`ifdef BSG_CACHE_NB_TXN_MONITOR_STATS_EN
    logic [63:0]       treq_m, tresp_m, treq_s, tresp_s;
    logic [2*CW_M-1:0] hwm_m;
    logic [2*CW_S-1:0] hwm_s;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct { int c0m; int c1m; int c0s; int c1s; } exp_t;
    exp_t sb[$];
    int   m_main[2];
    int   m_sat[2];

    always #5 clk = ~clk;

    bsg_cache_nb_txn_monitor #(
        .num_ports_p(2), .block_size_in_words_p(8), .max_outstanding_p(64), .timeout_p(16)
    ) dut_main (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_ready_i(req_ready),
        .req_block_i(req_block), .resp_v_i(resp_v), .resp_yumi_i(resp_yumi),
        .src_done_i(src_done), .outstanding_o(out_m), .done_o(done_m), .error_o(err_m),
        .error_code_o(code_m), .error_port_o(port_m)
`ifdef BSG_CACHE_NB_TXN_MONITOR_STATS_EN
        , .total_req_o(treq_m), .total_resp_o(tresp_m), .hwm_o(hwm_m)
`endif
    );

    bsg_cache_nb_txn_monitor #(
        .num_ports_p(2), .block_size_in_words_p(8), .max_outstanding_p(4), .timeout_p(0)
    ) dut_sat (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_ready_i(req_ready),
        .req_block_i(req_block), .resp_v_i(resp_v), .resp_yumi_i(resp_yumi),
        .src_done_i(src_done), .outstanding_o(out_s), .done_o(done_s), .error_o(err_s),
        .error_code_o(code_s), .error_port_o(port_s)
`ifdef BSG_CACHE_NB_TXN_MONITOR_STATS_EN
        , .total_req_o(treq_s), .total_resp_o(tresp_s), .hwm_o(hwm_s)
`endif
    );

    function automatic int model_next(int cnt, bit rf, bit blk, bit sf, int maxv);
        int n;
        if (sf && !rf && cnt == 0) return 0;
        n = cnt + (rf ? (blk ? 8 : 1) : 0) - (sf ? 1 : 0);
        if (n > maxv) n = maxv;
        return n;
    endfunction

    // one clock of stimulus; expected counts queued now, compared after the edge
    task automatic drive(input logic [1:0] rv, input logic [1:0] rdy, input logic [1:0] rb,
                         input logic [1:0] sv, input logic sd);
        exp_t e;
        req_v = rv; req_ready = rdy; req_block = rb;
        resp_v = sv; resp_yumi = 2'b11; src_done = sd;
        for (int p = 0; p < 2; p++) begin
            m_main[p] = model_next(m_main[p], rv[p] & rdy[p], rb[p], sv[p], 64);
            m_sat[p]  = model_next(m_sat[p],  rv[p] & rdy[p], rb[p], sv[p], 4);
        end
        sb.push_back('{m_main[0], m_main[1], m_sat[0], m_sat[1]});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks += 4;
        if (out_m[CW_M-1:0] !== CW_M'(e.c0m)) begin
            errors++; $display("FAIL cnt_main_p0 got %0d exp %0d", out_m[CW_M-1:0], e.c0m);
        end
        if (out_m[2*CW_M-1:CW_M] !== CW_M'(e.c1m)) begin
            errors++; $display("FAIL cnt_main_p1 got %0d exp %0d", out_m[2*CW_M-1:CW_M], e.c1m);
        end
        if (out_s[CW_S-1:0] !== CW_S'(e.c0s)) begin
            errors++; $display("FAIL cnt_sat_p0 got %0d exp %0d", out_s[CW_S-1:0], e.c0s);
        end
        if (out_s[2*CW_S-1:CW_S] !== CW_S'(e.c1s)) begin
            errors++; $display("FAIL cnt_sat_p1 got %0d exp %0d", out_s[2*CW_S-1:CW_S], e.c1s);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_v = '0; req_ready = '0; req_block = '0; resp_v = '0; resp_yumi = '0; src_done = 1'b0;
        m_main = '{0, 0}; m_sat = '{0, 0};
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks += 3;
        if (out_m !== '0 || out_s !== '0) begin
            errors++; $display("FAIL reset_cnt got %h/%h exp 0", out_m, out_s);
        end
        if ({done_m, err_m, done_s, err_s} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {done_m, err_m, done_s, err_s});
        end
        if ({code_m, port_m, code_s, port_s} !== 6'b0) begin
            errors++; $display("FAIL reset_code got %b exp 0", {code_m, port_m, code_s, port_s});
        end
        do_reset();
    endtask

    task automatic test_single_port();
        do_reset();
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);  // valid without ready: no fire
        for (int i = 0; i < 5; i++) drive(2'b01, 2'b11, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) drive(2'b00, 2'b11, 2'b00, 2'b01, 1'b0);
        drive(2'b00, 2'b11, 2'b00, 2'b01, 1'b1);
        for (int i = 0; i < 2 && done_m !== 1'b1; i++) drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        checks += 2;
        if (done_m !== 1'b1) begin
            errors++; $display("FAIL single_done got %b exp 1", done_m);
        end
        if (err_m !== 1'b0) begin
            errors++; $display("FAIL single_err got %b exp 0", err_m);
        end
    endtask

    task automatic test_block();
        do_reset();
        drive(2'b11, 2'b11, 2'b10, 2'b00, 1'b0);
        drive(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        for (int i = 0; i < 6; i++) drive(2'b00, 2'b11, 2'b00, 2'b10, 1'b0);
        drive(2'b00, 2'b11, 2'b00, 2'b10, 1'b1);
        for (int i = 0; i < 2 && done_m !== 1'b1; i++) drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        checks += 2;
        if (done_m !== 1'b1) begin
            errors++; $display("FAIL block_done got %b exp 1", done_m);
        end
        if (err_m !== 1'b0) begin
            errors++; $display("FAIL block_err got %b exp 0", err_m);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0);
        checks++;
        if (err_s !== 1'b0) begin
            errors++; $display("FAIL ovf_early got %b exp 0", err_s);
        end
        drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0);
        checks += 2;
        if ({err_s, code_s, port_s} !== {1'b1, 2'd1, 1'b1}) begin
            errors++; $display("FAIL ovf_code got %b/%0d/%0d exp 1/1/1", err_s, code_s, port_s);
        end
        if (err_m !== 1'b0) begin
            errors++; $display("FAIL ovf_main got %b exp 0", err_m);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        checks++;
        if ({err_m, code_m, port_m} !== {1'b1, 2'd2, 1'b0}) begin
            errors++; $display("FAIL unf_code got %b/%0d/%0d exp 1/2/0", err_m, code_m, port_m);
        end
        drive(2'b00, 2'b11, 2'b00, 2'b10, 1'b1);
        drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        checks += 2;
        if ({err_m, code_m, port_m} !== {1'b1, 2'd2, 1'b0}) begin
            errors++; $display("FAIL unf_sticky got %b/%0d/%0d exp 1/2/0", err_m, code_m, port_m);
        end
        if (done_m !== 1'b0) begin
            errors++; $display("FAIL unf_terminal got %b exp 0", done_m);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
            if (k == 15) begin
                checks++;
                if (err_m !== 1'b0) begin
                    errors++; $display("FAIL tmo_early got %b exp 0", err_m);
                end
            end
        end
        checks += 2;
        if ({err_m, code_m, port_m} !== {1'b1, 2'd3, 1'b1}) begin
            errors++; $display("FAIL tmo_code got %b/%0d/%0d exp 1/3/1", err_m, code_m, port_m);
        end
        if (err_s !== 1'b0) begin
            errors++; $display("FAIL tmo_disabled got %b exp 0", err_s);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        drive(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        drive(2'b01, 2'b11, 2'b00, 2'b00, 1'b0);
        drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        checks++;
        if (done_m !== 1'b0) begin
            errors++; $display("FAIL drain_done got %b exp 0", done_m);
        end
        #2 reset_n = 1'b0;
        #1;
        checks += 2;
        if (out_m !== '0 || out_s !== '0) begin
            errors++; $display("FAIL async_cnt got %h/%h exp 0", out_m, out_s);
        end
        if ({done_m, err_m} !== 2'b00) begin
            errors++; $display("FAIL async_flags got %b exp 00", {done_m, err_m});
        end
        m_main = '{0, 0}; m_sat = '{0, 0};
        req_v = '0; resp_v = '0; src_done = 1'b0;
        #2 reset_n = 1'b1;
        drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        checks++;
        if (done_m !== 1'b1) begin
            errors++; $display("FAIL idle_done got %b exp 1", done_m);
        end
        drive(2'b01, 2'b11, 2'b00, 2'b00, 1'b1);
        checks++;
        if (done_m !== 1'b0) begin
            errors++; $display("FAIL done_rerun got %b exp 0", done_m);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_block();
        test_overflow();
        test_underflow();
        test_timeout();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
